// File: rtl/multdiv_sequencer.sv
// Execute-stage controller for the shared multi-cycle multiply/divide unit: start pulse,
// pipeline stall while the unit works, and a single writeback of result or status code.
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT = 40  // legal range 2..63 (6-bit wait counter)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_valid,
  input  logic [4:0]  x_opcode,
  input  logic [4:0]  x_aluop,
  input  logic [4:0]  x_rd,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [4:0]  OpRtype     = 5'b00000;
  localparam logic [4:0]  AluMul      = 5'b00110;
  localparam logic [4:0]  AluDiv      = 5'b00111;
  localparam logic [4:0]  RegStatus   = 5'd30;
  localparam logic [31:0] CodeMulExc  = 32'd4;
  localparam logic [31:0] CodeDivExc  = 32'd5;
  localparam logic [31:0] CodeTimeout = 32'd6;
  localparam logic [5:0]  CntLast     = 6'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        is_div_q;
  logic [4:0]  rd_q;
  logic        ctrl_mult_q;
  logic        ctrl_div_q;
  logic        busy_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        detect;

  assign detect = x_valid && (x_opcode == OpRtype) &&
                  ((x_aluop == AluMul) || (x_aluop == AluDiv));

  // Reset gates stall so it drops in the same cycle, even if X still holds a mul/div.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      stall = ((state_q == StIdle) && detect) || (state_q == StStart) || (state_q == StWait);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      is_div_q    <= 1'b0;
      rd_q        <= 5'd0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      busy_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      busy_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      case (state_q)
        StIdle: begin
          if (detect) begin
            is_div_q    <= (x_aluop == AluDiv);
            rd_q        <= x_rd;
            ctrl_mult_q <= (x_aluop == AluMul);
            ctrl_div_q  <= (x_aluop == AluDiv);
            busy_q      <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          cnt_q   <= 6'd0;
          busy_q  <= 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 6'd1;
          // Ready takes priority over a coincident timeout.
          if (md_ready) begin
            state_q    <= StDone;
            wb_valid_q <= md_exception || (rd_q != 5'd0);
            wb_rd_q    <= md_exception ? RegStatus : rd_q;
            if (md_exception) begin
              wb_data_q <= is_div_q ? CodeDivExc : CodeMulExc;
            end else begin
              wb_data_q <= md_result;
            end
          end else if (cnt_q == CntLast) begin
            state_q    <= StDone;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= RegStatus;
            wb_data_q  <= CodeTimeout;
          end else begin
            busy_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ctrl_mult = ctrl_mult_q;
  assign ctrl_div  = ctrl_div_q;
  assign busy      = busy_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: directed vector table, reset abort sequence, and randomized
// operations checked against a per-transaction timeline model.
module tb_multdiv_sequencer;

  localparam int unsigned TO = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        x_valid = 1'b0;
  logic [4:0]  x_opcode = 5'd0;
  logic [4:0]  x_aluop = 5'd0;
  logic [4:0]  x_rd = 5'd0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic [31:0] md_result = 32'd0;
  logic        ctrl_mult, ctrl_div, stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  multdiv_sequencer #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x_opcode(x_opcode),
    .x_aluop(x_aluop), .x_rd(x_rd), .md_ready(md_ready), .md_exception(md_exception),
    .md_result(md_result), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall),
    .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_div;
    logic [4:0]  rd;
    int          lat;      // WAIT cycle (1-based) in which md_ready rises; 0 = never
    bit          exc;
    logic [31:0] res;
    bit          exp_v;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          exp_done; // cycle index of DONE, counted from detect at 0
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: when the writeback happens and what it carries.
  function automatic void model(input bit is_div, input logic [4:0] rd, input int lat,
                                input bit exc, input logic [31:0] res, output bit v,
                                output logic [4:0] wrd, output logic [31:0] wdata,
                                output int done_t);
    if (lat >= 1 && lat <= int'(TO)) begin
      done_t = lat + 2;
      if (exc) begin
        v = 1'b1; wrd = 5'd30; wdata = is_div ? 32'd5 : 32'd4;
      end else begin
        v = (rd != 5'd0); wrd = rd; wdata = res;
      end
    end else begin
      done_t = int'(TO) + 2;
      v = 1'b1; wrd = 5'd30; wdata = 32'd6;
    end
  endfunction

  task automatic run_op(input bit is_div, input logic [4:0] rd, input int lat, input bit exc,
                        input logic [31:0] res, input bit ev, input logic [4:0] erd,
                        input logic [31:0] edata, input int edone);
    for (int t = 0; t <= edone; t++) begin
      @(posedge clock);
      #1;
      x_valid  = 1'b1;
      x_opcode = 5'd0;
      x_aluop  = is_div ? 5'b00111 : 5'b00110;
      x_rd     = rd;
      if (t == 1) md_ready = 1'($urandom);  // must be ignored in START
      else md_ready = (lat != 0) && (t == lat + 1);
      md_exception = (md_ready && t != 1) ? exc : 1'($urandom);
      md_result    = (t == lat + 1) ? res : $urandom;
      @(negedge clock);
      chk($sformatf("stall t%0d", t), {31'd0, stall}, {31'd0, t < edone});
      chk($sformatf("busy t%0d", t), {31'd0, busy}, {31'd0, t >= 1 && t < edone});
      chk($sformatf("ctrl_mult t%0d", t), {31'd0, ctrl_mult}, {31'd0, t == 1 && !is_div});
      chk($sformatf("ctrl_div t%0d", t), {31'd0, ctrl_div}, {31'd0, t == 1 && is_div});
      chk($sformatf("wb_valid t%0d", t), {31'd0, wb_valid}, {31'd0, t == edone && ev});
      if (t == edone && ev) begin
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, erd});
        chk("wb_data", wb_data, edata);
      end
    end
  endtask

  task automatic idle_cycle();
    int kind;
    logic [4:0] op;
    @(posedge clock);
    #1;
    kind = $urandom_range(0, 2);
    x_valid  = 1'b1;
    x_opcode = 5'd0;
    x_aluop  = 5'b00110;
    x_rd     = 5'($urandom);
    if (kind == 0) begin
      x_valid = 1'b0;
    end else if (kind == 1) begin
      x_opcode = 5'($urandom_range(1, 31));
    end else begin
      do op = 5'($urandom); while (op == 5'b00110 || op == 5'b00111);
      x_aluop = op;
    end
    md_ready = 1'($urandom);
    md_exception = 1'($urandom);
    md_result = $urandom;
    @(negedge clock);
    chk("idle stall", {31'd0, stall}, 32'd0);
    chk("idle busy", {31'd0, busy}, 32'd0);
    chk("idle ctrl", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
    chk("idle wb_valid", {31'd0, wb_valid}, 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    bit          mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    int          mdone;

    tbl[0] = '{1'b0, 5'd5,  17, 1'b0, 32'd42,     1'b1, 5'd5,  32'd42,     19};
    tbl[1] = '{1'b1, 5'd9,  32, 1'b1, 32'd123,    1'b1, 5'd30, 32'd5,      34};
    tbl[2] = '{1'b0, 5'd3,  4,  1'b1, 32'd0,      1'b1, 5'd30, 32'd4,      6};
    tbl[3] = '{1'b0, 5'd12, 0,  1'b0, 32'd0,      1'b1, 5'd30, 32'd6,      42};
    tbl[4] = '{1'b0, 5'd0,  2,  1'b0, 32'd99,     1'b0, 5'd0,  32'd99,     4};
    tbl[5] = '{1'b1, 5'd7,  1,  1'b0, 32'd3,      1'b1, 5'd7,  32'd3,      3};
    tbl[6] = '{1'b1, 5'd20, 40, 1'b0, 32'h1234,   1'b1, 5'd20, 32'h1234,   42};
    tbl[7] = '{1'b1, 5'd1,  41, 1'b0, 32'd5,      1'b1, 5'd30, 32'd6,      42};

    // Reset state, with a mul presented in X to confirm stall stays low under reset.
    x_valid = 1'b1; x_aluop = 5'b00110; x_rd = 5'd4;
    @(negedge clock);
    @(negedge clock);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset ctrl", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
    chk("reset wb", {26'd0, wb_valid, wb_rd}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    x_valid = 1'b0;
    reset = 1'b0;

    // Directed table; entries 4 and 5 run back-to-back with no gap.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].is_div, tbl[i].rd, tbl[i].lat, tbl[i].exc, tbl[i].res,
             tbl[i].exp_v, tbl[i].exp_rd, tbl[i].exp_data, tbl[i].exp_done);
      if (i != 4) idle_cycle();
    end

    // Reset asserted in WAIT cycle 10 aborts the operation immediately.
    for (int t = 0; t <= 11; t++) begin
      @(posedge clock);
      #1;
      x_valid = 1'b1; x_opcode = 5'd0; x_aluop = 5'b00110; x_rd = 5'd4;
      md_ready = 1'b0;
      @(negedge clock);
      if (t == 1) chk("abort ctrl_mult", {31'd0, ctrl_mult}, 32'd1);
    end
    reset = 1'b1;
    #1;
    chk("abort stall", {31'd0, stall}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort wb_valid", {31'd0, wb_valid}, 32'd0);
    @(posedge clock);
    #1;
    chk("abort hold stall", {31'd0, stall}, 32'd0);
    chk("abort hold wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clock);
    x_valid = 1'b0;
    reset = 1'b0;
    run_op(1'b0, 5'd11, 3, 1'b0, 32'd77, 1'b1, 5'd11, 32'd77, 5);

    // Randomized operations with random gaps (zero gap exercises back-to-back issue).
    for (int n = 0; n < 30; n++) begin
      bit          is_div;
      logic [4:0]  rd;
      int          lat;
      bit          exc;
      logic [31:0] res;
      int          gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      is_div = 1'($urandom);
      rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      lat    = ($urandom_range(0, 2) != 0) ? $urandom_range(1, 8) : $urandom_range(0, TO + 3);
      exc    = ($urandom_range(0, 3) == 0);
      res    = $urandom;
      model(is_div, rd, lat, exc, res, mv, mrd, mdata, mdone);
      run_op(is_div, rd, lat, exc, res, mv, mrd, mdata, mdone);
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
